cpu_speed_ctrl: RTL and testbench

//  Synchronous successor to the clkctrl_phi1/phi2 CPU clock switchers, running entirely in the hsclk domain.

---
 rtl/cpu_speed_ctrl_pkg.sv | 21 ++
 rtl/cpu_clk_div.sv | 40 ++++
 rtl/cpu_speed_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cpu_speed_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_speed_ctrl_pkg.sv
// rtl/cpu_speed_ctrl_pkg.sv - state encodings and default parameters for the CPU speed controller
package cpu_speed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LS    = 2'b00,
    ST_TO_HS = 2'b01,
    ST_HS    = 2'b11,
    ST_TO_LS = 2'b10
  } speed_state_t;

  localparam int DEF_DIV_W    = 2;
  localparam int DEF_SYNC_CNT = 2;
  localparam int DEF_GUARD    = 2;
  localparam int DEF_TIMEOUT  = 255;

  // cpu_phi2 is parked low in both transition states
  function automatic logic is_switching(input speed_state_t s);
    return (s == ST_TO_HS) || (s == ST_TO_LS);
  endfunction

endpackage

// File: rtl/cpu_clk_div.sv
// rtl/cpu_clk_div.sv - hsclk divider and cpu_phi2 flop; follows lsclk_sync in LS, divides in HS
module cpu_clk_div #(
  parameter int DIV_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_follow,
  input  logic             i_follow_val,
  input  logic [DIV_W-1:0] i_div_sel,
  output logic             o_phi2,
  output logic             o_wrap
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_phi2;

  assign o_wrap = i_en & (r_cnt == i_div_sel);
  assign o_phi2 = r_phi2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_phi2 <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_phi2 <= 1'b0;
    end else if (i_follow) begin
      r_cnt  <= '0;
      r_phi2 <= i_follow_val;
    end else if (o_wrap) begin
      r_cnt  <= '0;
      r_phi2 <= ~r_phi2;
    end else if (i_en) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_speed_ctrl.sv
// rtl/cpu_speed_ctrl.sv - glitch-free LS/HS CPU clock switcher in the hsclk domain
// Optional TO_LS timeout and sticky tmo_err enabled by SPEED_CTRL_TIMEOUT_EN.
module cpu_speed_ctrl
  import cpu_speed_ctrl_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int SYNC_CNT = DEF_SYNC_CNT,
  parameter int GUARD    = DEF_GUARD
`ifdef SPEED_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = DEF_TIMEOUT
`endif
) (
  input  logic             i_hsclk,
  input  logic             i_rst,
  input  logic             i_lsclk_sync,
  input  logic             i_hsclk_en,
  input  logic [DIV_W-1:0] i_div_sel,
  input  logic             i_cpu_vpa,
  input  logic             i_cpu_vda,
  input  logic             i_himem,
  output logic             o_cpu_phi2,
  output logic             o_hs_selected,
  output logic             o_ls_selected,
  output logic             o_dummy_access,
  output logic             o_tmo_err
);

  localparam int SC_W = $clog2(SYNC_CNT + 1);
  localparam int GD_W = $clog2(GUARD + 1);

  speed_state_t     r_state;
  logic [SC_W-1:0]  r_sync_cnt;
  logic [SC_W-1:0]  w_cnt_nxt;
  logic [GD_W-1:0]  r_guard_cnt;
  logic [DIV_W-1:0] r_div_sel;
  logic             r_ls_prev;
  logic             r_hs;
  logic             r_ls;
  logic             r_dummy;
  logic             w_phi2;
  logic             w_wrap;
  logic             w_s;
  logic             w_hs_exit;
  logic             w_ls_fall;
  logic             w_clr;

`ifdef SPEED_CTRL_TIMEOUT_EN
  localparam int T_W = $clog2(TIMEOUT + 1);
  logic [T_W-1:0]   r_tmo_cnt;
  logic             r_tmo_err;
  assign o_tmo_err = r_tmo_err;
`else
  assign o_tmo_err = 1'b0;
`endif

  // S: the edge on which cpu_phi2 falls; all CPU-side inputs are sampled only here
  assign w_s = w_phi2 & (((r_state == ST_LS) & ~i_lsclk_sync) |
                         ((r_state == ST_HS) & w_wrap));
  assign w_hs_exit = w_s & (r_state == ST_HS) &
                     (((i_cpu_vpa | i_cpu_vda) & ~i_himem) | ~i_hsclk_en);
  assign w_ls_fall = r_ls_prev & ~i_lsclk_sync;
  assign w_clr     = is_switching(r_state) | w_hs_exit;

  always_comb begin
    w_cnt_nxt = r_sync_cnt;
    if (i_cpu_vpa & i_cpu_vda) begin
      if (!i_himem)
        w_cnt_nxt = '0;
      else if (r_sync_cnt != SC_W'(SYNC_CNT))
        w_cnt_nxt = r_sync_cnt + 1'b1;
    end
  end

  cpu_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .i_clk       (i_hsclk),
    .i_rst       (i_rst),
    .i_en        (r_state == ST_HS),
    .i_clr       (w_clr),
    .i_follow    (r_state == ST_LS),
    .i_follow_val(i_lsclk_sync),
    .i_div_sel   (r_div_sel),
    .o_phi2      (w_phi2),
    .o_wrap      (w_wrap)
  );

  always_ff @(posedge i_hsclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_LS;
      r_sync_cnt  <= '0;
      r_guard_cnt <= '0;
      r_div_sel   <= '0;
      r_ls_prev   <= 1'b0;
      r_hs        <= 1'b0;
      r_ls        <= 1'b1;
      r_dummy     <= 1'b0;
`ifdef SPEED_CTRL_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_tmo_err   <= 1'b0;
`endif
    end else begin
      r_ls_prev <= i_lsclk_sync;
      if (w_s)
        r_div_sel <= i_div_sel;
      if (r_state != ST_LS)
        r_dummy <= 1'b1;
      else if (w_s)
        r_dummy <= i_himem;

      case (r_state)
        ST_LS: begin
          if (w_s) begin
            if ((w_cnt_nxt == SC_W'(SYNC_CNT)) && i_hsclk_en) begin
              r_state     <= ST_TO_HS;
              r_sync_cnt  <= '0;
              r_guard_cnt <= '0;
              r_ls        <= 1'b0;
            end else begin
              r_sync_cnt  <= w_cnt_nxt;
            end
          end
        end
        ST_TO_HS: begin
          if (r_guard_cnt == GD_W'(GUARD - 1)) begin
            r_state <= ST_HS;
            r_hs    <= 1'b1;
          end else begin
            r_guard_cnt <= r_guard_cnt + 1'b1;
          end
        end
        ST_HS: begin
          if (w_hs_exit) begin
            r_state   <= ST_TO_LS;
            r_hs      <= 1'b0;
`ifdef SPEED_CTRL_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        ST_TO_LS: begin
          // a falling BBC edge guarantees LS resumes with a full low phase
          if (w_ls_fall) begin
            r_state <= ST_LS;
            r_ls    <= 1'b1;
          end
`ifdef SPEED_CTRL_TIMEOUT_EN
          else if (r_tmo_cnt == T_W'(TIMEOUT - 1)) begin
            r_state   <= ST_LS;
            r_ls      <= 1'b1;
            r_tmo_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= ST_LS;
      endcase
    end
  end

  assign o_cpu_phi2     = w_phi2;
  assign o_hs_selected  = r_hs;
  assign o_ls_selected  = r_ls;
  assign o_dummy_access = r_dummy;

endmodule

// File: tb/tb_cpu_speed_ctrl.sv
// tb/tb_cpu_speed_ctrl.sv - self-checking bench for cpu_speed_ctrl
module tb_cpu_speed_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       lsclk;
  logic       en;
  logic [1:0] div_sel;
  logic       vpa;
  logic       vda;
  logic       himem;
  logic       phi2;
  logic       hs;
  logic       ls;
  logic       dummy;
  logic       tmo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic vpa;
    logic vda;
    logic himem;
    logic en;
    logic exp_ls;
    logic exp_dummy;
  } ls_vec_t;

  typedef struct {
    logic [1:0] sel;
    int         half;
  } div_vec_t;

  ls_vec_t  ls_tab[8];
  div_vec_t div_tab[5];
  ls_vec_t  exp_q[$];
  logic     follow_q[$];
  int       half_q[$];

  cpu_speed_ctrl dut (
    .i_hsclk       (clk),
    .i_rst         (rst),
    .i_lsclk_sync  (lsclk),
    .i_hsclk_en    (en),
    .i_div_sel     (div_sel),
    .i_cpu_vpa     (vpa),
    .i_cpu_vda     (vda),
    .i_himem       (himem),
    .o_cpu_phi2    (phi2),
    .o_hs_selected (hs),
    .o_ls_selected (ls),
    .o_dummy_access(dummy),
    .o_tmo_err     (tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_phi2"}, phi2, 0);
    check({name, "_ls"}, ls, 1);
    check({name, "_hs"}, hs, 0);
    check({name, "_dummy"}, dummy, 0);
    check({name, "_tmo"}, tmo, 0);
  endtask

  task automatic wait_phi2(input logic v, output int n);
    n = 0;
    while (phi2 !== v && n < 64) begin
      tick();
      n++;
    end
    if (phi2 !== v) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_phi2 timeout: got %b expected %b", phi2, v);
    end
  endtask

  task automatic wait_flag(input string name, input bit use_ls, input logic v,
                           input int bound, output int n);
    n = 0;
    while (((use_ls ? ls : hs) !== v) && n < bound) begin
      tick();
      n++;
    end
    if ((use_ls ? ls : hs) !== v) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: got %b expected %b", name, (use_ls ? ls : hs), v);
    end
  endtask

  // one BBC high phase, then the falling edge that is the LS sample point
  task automatic bbc_to_s();
    lsclk = 1'b1;
    repeat (8) tick();
    lsclk = 1'b0;
    tick();
  endtask

  initial begin
    int      n;
    int      nlo;
    int      nhi;
    int      h;
    logic    ok;
    ls_vec_t e;

    rst = 1'b1; lsclk = 1'b0; en = 1'b0; div_sel = 2'd0;
    vpa = 1'b0; vda = 1'b0; himem = 1'b0;

    ls_tab[0] = '{1, 1, 1, 1, 1, 1};
    ls_tab[1] = '{0, 1, 1, 1, 1, 1};
    ls_tab[2] = '{1, 1, 0, 1, 1, 0};
    ls_tab[3] = '{1, 1, 1, 1, 1, 1};
    ls_tab[4] = '{1, 1, 1, 0, 1, 1};
    ls_tab[5] = '{1, 1, 1, 0, 1, 1};
    ls_tab[6] = '{1, 0, 0, 0, 1, 0};
    ls_tab[7] = '{0, 1, 1, 1, 0, 1};

    div_tab[0] = '{2'd0, 1};
    div_tab[1] = '{2'd3, 4};
    div_tab[2] = '{2'd1, 2};
    div_tab[3] = '{2'd2, 3};
    div_tab[4] = '{2'd0, 1};

    for (int k = 0; k < 3; k++) begin
      lsclk = ((k % 16) < 8);
      tick();
    end
    check_reset("rst_hold");
    rst = 1'b0;
    for (int k = 3; k < 51; k++) begin
      lsclk = ((k % 16) < 8);
      follow_q.push_back(lsclk);
      tick();
      check("ls_follow", phi2, follow_q.pop_front());
    end
    check("ls_follow_ls", ls, 1);
    check("ls_follow_hs", hs, 0);
    check("ls_follow_dummy", dummy, 0);

    for (int i = 0; i < 8; i++) begin
      vpa = ls_tab[i].vpa; vda = ls_tab[i].vda;
      himem = ls_tab[i].himem; en = ls_tab[i].en;
      exp_q.push_back(ls_tab[i]);
      bbc_to_s();
      e = exp_q.pop_front();
      check($sformatf("ls_tab%0d_ls", i), ls, e.exp_ls);
      check($sformatf("ls_tab%0d_dummy", i), dummy, e.exp_dummy);
      check($sformatf("ls_tab%0d_hs", i), hs, 0);
      check($sformatf("ls_tab%0d_phi2", i), phi2, 0);
      if (ls) repeat (7) tick();
    end

    tick();
    check("guard1_hs", hs, 0);
    check("guard1_ls", ls, 0);
    check("guard1_phi2", phi2, 0);
    tick();
    check("guard2_hs", hs, 1);
    check("guard2_phi2", phi2, 0);
    tick();
    check("hs_first_rise", phi2, 1);

    for (int i = 0; i < 5; i++) begin
      div_sel = div_tab[i].sel;
      half_q.push_back(div_tab[i].half);
      wait_phi2(1'b1, n);
      wait_phi2(1'b0, n);
      wait_phi2(1'b1, nlo);
      wait_phi2(1'b0, nhi);
      h = half_q.pop_front();
      check($sformatf("div%0d_low", i), nlo, h);
      check($sformatf("div%0d_high", i), nhi, h);
      check($sformatf("div%0d_hs", i), hs, 1);
      check($sformatf("div%0d_dummy", i), dummy, 1);
    end

    lsclk = 1'b1;
    tick();
    vpa = 1'b0; vda = 1'b1; himem = 1'b0;
    wait_flag("exit_hs", 1'b0, 1'b0, 64, n);
    check("to_ls_phi2", phi2, 0);
    check("to_ls_ls", ls, 0);
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (phi2 !== 1'b0 || ls !== 1'b0) ok = 1'b0;
    end
    check("to_ls_hold", ok, 1);
    lsclk = 1'b0;
    tick();
    check("back_ls_ls", ls, 1);
    check("back_ls_phi2", phi2, 0);
    tick();
    check("back_ls_low", phi2, 0);
    check("back_ls_dummy", dummy, 1);
    lsclk = 1'b1;
    tick();
    check("back_ls_follow", phi2, 1);
    lsclk = 1'b0;
    tick();
    check("back_ls_dummy_s", dummy, 0);
    check("back_ls_tmo", tmo, 0);

`ifdef SPEED_CTRL_TIMEOUT_EN
    vpa = 1'b1; vda = 1'b1; himem = 1'b1; en = 1'b1;
    bbc_to_s();
    bbc_to_s();
    check("tmo_to_hs_ls", ls, 0);
    wait_flag("tmo_enter_hs", 1'b0, 1'b1, 16, n);
    lsclk = 1'b1;
    vpa = 1'b0; vda = 1'b1; himem = 1'b0;
    wait_flag("tmo_exit_hs", 1'b0, 1'b0, 64, n);
    wait_flag("tmo_wait_ls", 1'b1, 1'b1, 400, n);
    check("tmo_cycles", n, 255);
    check("tmo_err_set", tmo, 1);
    check("tmo_phi2", phi2, 0);
    vpa = 1'b0; vda = 1'b0;
    bbc_to_s();
    check("tmo_err_sticky", tmo, 1);
    check("tmo_ls_stays", ls, 1);
`endif

    vpa = 1'b1; vda = 1'b1; himem = 1'b1; en = 1'b1;
    bbc_to_s();
    bbc_to_s();
    check("pre_rst_to_hs_ls", ls, 0);
    check("pre_rst_to_hs_hs", hs, 0);
    #1 rst = 1'b1;
    #1 check_reset("rst_to_hs");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_to_hs_release_ls", ls, 1);

    bbc_to_s();
    bbc_to_s();
    wait_flag("pre_rst_hs", 1'b0, 1'b1, 16, n);
    wait_phi2(1'b1, n);
    check("pre_rst_hs_phi2", phi2, 1);
    #1 rst = 1'b1;
    #1 check_reset("rst_hs");
    tick();
    rst = 1'b0;
    tick();
    check("rst_hs_release_ls", ls, 1);
    check("rst_hs_release_hs", hs, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
